// File: rtl/regfile_dump_reader.sv
// ============================================================================
// regfile_dump_reader: walks the register file read port and streams every
// word with its index over valid/ready, accumulating an XOR checksum.
// Optional: REGDUMP_SKIP_ZERO_EN skips hardwired-zero register 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_ReadAddress,
  input  logic [DATA_WIDTH-1:0] i_ReadData,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_checksum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef REGDUMP_SKIP_ZERO_EN
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
`else
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(0);
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] cksum_q, cksum_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    cksum_d = cksum_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cksum_d = '0;
          ptr_d   = FIRST_IDX;
          state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = i_ReadData;
        addr_d  = ptr_q;
        last_d  = (ptr_q == LAST_IDX);
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && i_ready) begin
          cksum_d = cksum_q ^ data_q;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        // Park the read port on the first index so IDLE presents it.
        ptr_d   = FIRST_IDX;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      ptr_q   <= FIRST_IDX;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      cksum_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      cksum_q <= cksum_d;
    end
  end

  assign o_ReadAddress = ptr_q;
  assign o_valid       = valid_q;
  assign o_data        = data_q;
  assign o_addr        = addr_q;
  assign o_last        = last_q;
  assign o_checksum    = cksum_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected words are queued at start
// and popped on each accepted handshake.
`default_nettype none

module tb_regfile_dump_reader;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
`ifdef REGDUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int LAT = 2 * (NR - FIRST);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [AW-1:0] ra;
  logic [DW-1:0] rdata;
  logic          valid;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          last;
  logic          busy;
  logic          done;
  logic [DW-1:0] cksum;

  logic [DW-1:0] regs [NR];
  assign rdata = regs[ra];

  always #5 clk = ~clk;

  regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .o_ReadAddress(ra),
    .i_ReadData(rdata), .o_valid(valid), .i_ready(ready), .o_data(data),
    .o_addr(addr), .o_last(last), .o_busy(busy), .o_done(done),
    .o_checksum(cksum)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            handshakes;
  int            done_cnt;
  logic          stall_prev;
  logic [DW-1:0] held_data;
  logic [AW-1:0] held_addr;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    word_t w;
    if (stall_prev) begin
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_data", data, held_data);
      chk("stall_addr", 32'(addr), 32'(held_addr));
    end
    stall_prev = valid && !ready;
    held_data  = data;
    held_addr  = addr;
    if (valid && ready) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("addr", 32'(addr), 32'(w.addr));
      chk("data", data, w.data);
      chk("last", 32'(last), 32'(w.last));
      handshakes++;
    end
    if (done) done_cnt++;
`ifdef REGDUMP_SKIP_ZERO_EN
    chk("ra_nonzero", 32'(ra == '0), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_last"}, 32'(last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_cksum"}, cksum, 32'd0);
    chk({tag, "_raddr"}, 32'(ra), 32'(FIRST));
  endtask

  // toggle: i_ready alternates; restart_at: extra start after that many words;
  // abort_cyc: stall then reset at that cycle; exp_lat: start-to-DONE cycles.
  task automatic run_dump(input bit toggle, input int restart_at, input int abort_cyc,
                          input int exp_lat);
    logic [DW-1:0] ck;
    int            done_cyc;
    bit            restarted;
    ck = '0;
    done_cyc = -1;
    restarted = 1'b0;
    exp_q.delete();
    for (int i = FIRST; i < NR; i++) begin
      exp_q.push_back('{addr: AW'(i), data: regs[i], last: (i == NR - 1)});
      ck ^= regs[i];
    end
    handshakes = 0;
    done_cnt   = 0;
    stall_prev = 1'b0;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("busy_after_start", 32'(busy), 32'd1);
      monitor();
      if (cyc == abort_cyc) begin
        chk("abort_addr", 32'(addr), 32'd7);
        chk("abort_valid", 32'(valid), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        #1 rst = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        return;
      end
      if (done && done_cyc < 0) begin
        done_cyc = cyc;
        chk("checksum", cksum, ck);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 3) break;
      @(posedge clk);
      #1;
      ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (cyc + 1 == abort_cyc) ready = 1'b0;
      start = 1'b0;
      if (restart_at >= 0 && handshakes == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("word_count", 32'(handshakes), 32'(NR - FIRST));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    if (exp_lat >= 0) chk("latency", 32'(done_cyc), 32'(exp_lat));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_raddr", 32'(ra), 32'(FIRST));
    chk("checksum_hold", cksum, ck);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    stall_prev = 1'b0;
    for (int i = 0; i < NR; i++) regs[i] = DW'(i);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_dump(1'b0, -1, -1, LAT);
    run_dump(1'b1, -1, -1, -1);

    for (int i = 0; i < NR; i++) regs[i] = 32'hA5A5_0000 | DW'(i);
    run_dump(1'b0, -1, -1, LAT);
    regs[5] = 32'hFFFF_FFFF;
    run_dump(1'b0, -1, -1, LAT);

    for (int i = 0; i < NR; i++) regs[i] = DW'(i);
    run_dump(1'b0, 10, -1, LAT);

    run_dump(1'b0, -1, 15, -1);
    run_dump(1'b0, -1, -1, LAT);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-side engine for the CPU's 32×32 register file. On a start pulse it walks the file's read address port through every register, captures each word, and presents it on a valid/ready stream with its index. A running XOR checksum is accumulated as words are sent. It drives one read port of the register file, which is otherwise idle during debug halt, and feeds the debug/trace path.

## Interface
- DATA_WIDTH, 32, register word width
- ADDR_WIDTH, 5, register index width
- NUM_REGS, 32, registers walked; last index = NUM_REGS-1
- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  reset; asynchronous, active-high
- i_start  in  1  single-cycle pulse; starts a dump when idle
- o_ReadAddress  out  ADDR_WIDTH  to register file read address
- i_ReadData  in  DATA_WIDTH  register file read data, combinational from o_ReadAddress
- o_valid  out  1  stream word valid
- i_ready  in  1  downstream accepts word
- o_data  out  DATA_WIDTH  captured register value
- o_addr  out  ADDR_WIDTH  index of o_data
- o_last  out  1  high with the final word of the dump
- o_busy  out  1  high from start acceptance until return to IDLE
- o_done  out  1  one-cycle pulse after the last word is accepted
- o_checksum  out  DATA_WIDTH  XOR of all words accepted in the current/last dump

## Operation
- States: IDLE, READ, SEND, DONE. Reset → IDLE.
- IDLE: o_ReadAddress = first index, o_busy = 0. i_start=1 → clear checksum, ptr ← first index, → READ.
- READ: o_ReadAddress = ptr. At the edge: o_data ← i_ReadData, o_addr ← ptr, o_last ← (ptr == NUM_REGS-1), o_valid ← 1, → SEND.
- SEND: o_valid=1, with o_data/o_addr/o_last held stable until handshake. On o_valid & i_ready: checksum ^= o_data, o_valid ← 0. If o_last → DONE, else ptr ← ptr+1 → READ.
- DONE: o_done=1 for exactly this cycle, → IDLE. o_checksum holds until the next start.
- i_start while not in IDLE is ignored (no restart, no queueing).
- ptr never wraps: the dump terminates at NUM_REGS-1.
- o_ReadAddress is registered (driven from ptr); i_ReadData sampled only in READ.
- Reset in any state: immediately → IDLE; o_valid, o_last, o_done, o_busy = 0; o_data, o_addr, o_checksum, o_ReadAddress = 0 (first index when REGDUMP_SKIP_ZERO_EN).

## Timing
- Start sampled at edge N → READ during cycle N+1 → o_valid high after edge N+1.
- With i_ready held high: one word every 2 cycles; a full 32-word dump takes 64 cycles from start to the DONE cycle, plus 1 for o_done.
- Backpressure: each cycle i_ready is low in SEND adds one cycle; outputs stay frozen.
- o_busy is high from the cycle after start through the DONE cycle inclusive.
- The register file may be written during a dump. Each word reflects the file contents in its own READ cycle; no snapshot is taken.

## Configuration
- REGDUMP_SKIP_ZERO_EN defined: first index = 1. Register 0 (hardwired zero) is never read or sent. The dump is NUM_REGS-1 words and o_addr starts at 1.
- Not defined: first index = 0. The dump is NUM_REGS words starting at o_addr=0.

## Test plan
- File preloaded Register[i]=i, i_ready=1, start pulse → 32 words, o_addr=o_data=0..31, o_last only on 31, o_done one cycle, o_checksum=0x00000000, DONE cycle is 64 cycles after start.
- Same preload, i_ready toggling 1/0 every cycle → identical word sequence with no drops or duplicates, and o_data/o_addr stable throughout each stall.
- Preload Register[i]=0xA5A50000|i → o_checksum = XOR of all 32 words = 0x00000000; set Register[5]=0xFFFFFFFF instead → checksum 0xFFFFFFFF ^ 0xA5A50005 = 0x5A5AFFFA.
- Pulse i_start again at word 10 → ignored; the dump completes normally with exactly one o_done.
- Assert i_reset while in SEND at word 7 → all outputs 0 asynchronously; a new start restarts at index 0.
- With REGDUMP_SKIP_ZERO_EN defined, i_ready=1 → 31 words with o_addr 1..31 and o_last on 31; o_ReadAddress never equals 0 after reset.
